// File: rtl/sr_latch_writer.sv
// Write controller for an external SR latch: drives S/R around an E pulse,
// then checks synchronized Q/Qbar feedback and retries a bounded number of times.
//
// state  | meaning
// IDLE   | ready for a request; done/err pulse shows here
// SETUP  | S/R driven, E low
// PULSE  | S/R driven, E high
// HOLD   | S/R driven, E low
// SETTLE | all drives low, feedback propagates through synchronizers
// CHECK  | compare synchronized feedback against captured data
module sr_latch_writer #(
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 1,
  parameter int SETTLE_CYC = 2,
  parameter int RETRY_MAX  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_data,
  output logic req_ready,
  output logic S,
  output logic R,
  output logic E,
  input  logic Q_fb,
  input  logic Qbar_fb,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int CW = 16;
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
    HOLD   = 3'd3,
    SETTLE = 3'd4,
    CHECK  = 3'd5
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_retry;
  logic          r_data;
  logic [1:0]    r_q_sync;
  logic [1:0]    r_qb_sync;
  logic          r_s;
  logic          r_r;
  logic          r_e;
  logic          r_done;
  logic          r_err;
  logic          w_pass;

  // A Q==Qbar reading always fails one of the two terms.
  assign w_pass = (r_q_sync[1] == r_data) && (r_qb_sync[1] == ~r_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_data    <= 1'b0;
      r_q_sync  <= 2'b00;
      r_qb_sync <= 2'b00;
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_e       <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_q_sync  <= {r_q_sync[0], Q_fb};
      r_qb_sync <= {r_qb_sync[0], Qbar_fb};
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_data  <= req_data;
            r_retry <= '0;
            r_cnt   <= CW'(SETUP_CYC - 1);
            r_s     <= req_data;
            r_r     <= ~req_data;
            r_e     <= 1'b0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_cnt   <= CW'(PULSE_CYC - 1);
            r_e     <= 1'b1;
            r_state <= PULSE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        PULSE: begin
          if (r_cnt == '0) begin
            r_cnt   <= CW'(HOLD_CYC - 1);
            r_e     <= 1'b0;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
            r_cnt   <= CW'(SETTLE_CYC - 1);
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_state <= SETTLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= CHECK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        CHECK: begin
          if (w_pass) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (r_retry == RW'(RETRY_MAX)) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_retry <= r_retry + 1'b1;
            r_cnt   <= CW'(SETUP_CYC - 1);
            r_s     <= r_data;
            r_r     <= ~r_data;
            r_state <= SETUP;
          end
        end
        default: begin
          r_state <= IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_e     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (r_state == IDLE) && !reset;
  assign busy      = (r_state != IDLE);
  assign S         = r_s;
  assign R         = r_r;
  assign E         = r_e;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: doc/sr_latch_writer.md
SR_LATCH_WRITER -- requirements
Module: sr_latch_writer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be:
- SETUP_CYC, default 1, cycles S/R are driven before E rises (≥1).
- PULSE_CYC, default 2, cycles E is held high (≥1).
- HOLD_CYC, default 1, cycles S/R are held after E falls (≥1).
- SETTLE_CYC, default 2, cycles waited before feedback is checked (≥2).
- RETRY_MAX, default 2, extra write attempts after a failed check (≥0).

REQ-003 Ports SHALL be:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- req_valid  input  1  write request.
- req_data  input  1  bit to store in the latch.
- req_ready  output  1  request accepted when req_valid & req_ready at the clk edge.
- S  output  1  latch set drive.
- R  output  1  latch reset drive.
- E  output  1  latch enable drive.
- Q_fb  input  1  latch Q feedback (asynchronous).
- Qbar_fb  input  1  latch Qbar feedback (asynchronous).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse: write verified.
- err  output  1  one-cycle pulse: write failed after all retries.

Function
REQ-004 The FSM SHALL have the states IDLE, SETUP, PULSE, HOLD, SETTLE and CHECK.
REQ-005 In IDLE, req_ready SHALL be 1 (0 while reset is high); on acceptance, req_data is captured, the retry count is cleared, and the FSM goes to SETUP.
REQ-006 SETUP SHALL last SETUP_CYC cycles with S=data, R=~data and E=0.
REQ-007 PULSE SHALL last PULSE_CYC cycles with S=data, R=~data and E=1.
REQ-008 HOLD SHALL last HOLD_CYC cycles with S=data, R=~data and E=0.
REQ-009 SETTLE SHALL last SETTLE_CYC cycles with S=R=E=0.
REQ-010 Outside SETUP, PULSE and HOLD, S, R and E SHALL be 0.
REQ-011 S=R=1 SHALL never occur.
REQ-012 S, R and E SHALL be registered outputs (glitch-free).
REQ-013 Q_fb and Qbar_fb SHALL each pass through a two-flop synchronizer; CHECK uses only the synchronized values.
REQ-014 CHECK SHALL last 1 cycle and pass iff Q_sync==data and Qbar_sync==~data; Q_sync==Qbar_sync is a fail.
REQ-015 On a CHECK pass, the FSM SHALL go to IDLE and done SHALL be 1 in that first IDLE cycle.
REQ-016 On a CHECK fail with retry count < RETRY_MAX, the count SHALL increment and the FSM go to SETUP.
REQ-017 On a CHECK fail with retry count == RETRY_MAX, the FSM SHALL go to IDLE and err SHALL be 1 in that first IDLE cycle.
REQ-018 Latency from the acceptance edge to the done/err cycle SHALL be 1+SETUP_CYC+PULSE_CYC+HOLD_CYC+SETTLE_CYC+1 cycles (8 with defaults).
REQ-019 Each retry SHALL add SETUP_CYC+PULSE_CYC+HOLD_CYC+SETTLE_CYC+1 cycles (7 with defaults).
REQ-020 req_valid while busy SHALL be ignored and SHALL not be queued.
REQ-021 A request presented in the done/err cycle SHALL be accepted, allowing back-to-back writes.
REQ-022 done and err SHALL never be high together, and each SHALL be high for exactly one cycle per request.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 At a clk edge with reset=1, the block SHALL enter IDLE with S=R=E=0, busy=done=err=0, the retry count and all phase counters at 0, and synchronizer flops at 0.
REQ-025 Reset SHALL take priority over an in-flight write and over a simultaneous req_valid; the aborted request produces no done or err.
REQ-026 req_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-027 Reset, then write req_data=1 with a correct latch model -> S=1,R=0 for 4 cycles, E=1 for exactly 2 cycles, done=1 at cycle 8, err stays 0.
REQ-028 Write req_data=0 -> R=1,S=0, E pulse of 2 cycles, done at cycle 8, and the latch model Q=0.
REQ-029 Q_fb stuck at 0 during a write of 1 -> 3 E pulses, err=1 at cycle 22, done never asserts.
REQ-030 First attempt fails (model ignores E), then the model is fixed -> done=1 at cycle 15, with 2 E pulses.
REQ-031 Reset asserted during PULSE -> the next cycle has S=R=E=0 and busy=0, with no done/err; req_ready=1 one cycle after reset is released.
REQ-032 req_valid held high continuously with alternating data -> exactly one acceptance per 8 cycles, accepted in each done cycle, with S=R=1 never observed.
